udp_request_initiator: RTL

- Hardware client for the UDP test-server path: on a start pulse it sends one single-beat request on an AXI-Stream TX interface with UDP metadata (remote IP, remote port, local port).
- It then waits, with a timeout, for the matching response on an AXI-Stream RX interface.
- It captures the first response beat and reports done/error.
- It sits on the host-facing end of the same stream/metadata interface the server consumes and produces, and serves as the on-chip requester for loopback and self-test.

---
 rtl/udp_request_initiator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/udp_request_initiator.sv
// udp_request_initiator: issues one single-beat UDP request on AXI-Stream TX, then waits
// (with timeout) for the first RX beat whose metadata matches and reports done/error.
// Latency: TX beat valid 1 cycle after i_start; o_done 1 cycle after terminating handshake/expiry.
// Backpressure: SEND waits on i_tx_TREADY indefinitely; RX is stalled (TREADY=0) outside WAIT_RSP/DRAIN.
// Ports: i_clk/i_reset (sync, active high); i_start + i_req_* request fields; o_tx_* request stream
// with latched UDP metadata; i_rx_* response stream with metadata; o_busy/o_done/o_err_timeout status;
// o_rsp_* captured first matching beat; o_drop_count saturating count of discarded non-matching beats.
module udp_request_initiator #(
  parameter int DATA_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [DATA_WIDTH-1:0]   i_req_data,
  input  logic [DATA_WIDTH/8-1:0] i_req_keep,
  input  logic [31:0]             i_req_remote_ip,
  input  logic [15:0]             i_req_remote_port,
  input  logic [15:0]             i_req_local_port,
  output logic                    o_tx_TVALID,
  input  logic                    i_tx_TREADY,
  output logic [DATA_WIDTH-1:0]   o_tx_TDATA,
  output logic [DATA_WIDTH/8-1:0] o_tx_TKEEP,
  output logic                    o_tx_TLAST,
  output logic [31:0]             o_remote_ip_tx,
  output logic [15:0]             o_remote_port_tx,
  output logic [15:0]             o_local_port_tx,
  input  logic                    i_rx_TVALID,
  output logic                    o_rx_TREADY,
  input  logic [DATA_WIDTH-1:0]   i_rx_TDATA,
  input  logic [DATA_WIDTH/8-1:0] i_rx_TKEEP,
  input  logic                    i_rx_TLAST,
  input  logic [31:0]             i_remote_ip_rx,
  input  logic [15:0]             i_remote_port_rx,
  input  logic [15:0]             i_local_port_rx,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err_timeout,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [DATA_WIDTH/8-1:0] o_rsp_keep,
  output logic [CNT_WIDTH-1:0]    o_drop_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  req_data;
  logic [KW-1:0]          req_keep;
  logic [31:0]            req_ip;
  logic [15:0]            req_rport;
  logic [15:0]            req_lport;
  logic [TW-1:0]          tmo_cnt;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic [KW-1:0]          rsp_keep;
  logic [CNT_WIDTH-1:0]   drop_cnt;
  logic                   done_q;
  logic                   err_q;

  logic match, latch, capture, drop, finish, timeout, cnt_clr, cnt_inc;
  logic tx_vld, rx_rdy;

  assign match = (i_remote_ip_rx == req_ip) && (i_remote_port_rx == req_rport) &&
                 (i_local_port_rx == req_lport);

  always_comb begin
    state_nxt = state;
    tx_vld    = 1'b0;
    rx_rdy    = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    finish    = 1'b0;
    timeout   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          latch     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_vld = 1'b1;
        if (i_tx_TREADY) begin
          cnt_clr   = 1'b1;
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        rx_rdy = 1'b1;
        if (i_rx_TVALID && match) begin
          // A match in the expiry cycle takes priority over the timeout.
          capture = 1'b1;
          cnt_clr = 1'b1;
          if (i_rx_TLAST) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DRAIN;
          end
        end else begin
          // Foreign beats are swallowed but do not refresh the timeout.
          drop = i_rx_TVALID;
          if (tmo_cnt == TMO_LAST) begin
            timeout   = 1'b1;
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        rx_rdy = 1'b1;
        if (i_rx_TVALID) begin
          cnt_clr = 1'b1;
          if (i_rx_TLAST) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          timeout   = 1'b1;
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      req_data  <= '0;
      req_keep  <= '0;
      req_ip    <= '0;
      req_rport <= '0;
      req_lport <= '0;
      tmo_cnt   <= '0;
      rsp_data  <= '0;
      rsp_keep  <= '0;
      drop_cnt  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;
      if (latch) begin
        req_data  <= i_req_data;
        req_keep  <= i_req_keep;
        req_ip    <= i_req_remote_ip;
        req_rport <= i_req_remote_port;
        req_lport <= i_req_local_port;
        err_q     <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
      if (cnt_clr)      tmo_cnt <= '0;
      else if (cnt_inc) tmo_cnt <= tmo_cnt + TW'(1);
      if (capture) begin
        rsp_data <= i_rx_TDATA;
        rsp_keep <= i_rx_TKEEP;
      end
      if (drop && (drop_cnt != {CNT_WIDTH{1'b1}})) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_tx_TVALID      = tx_vld;
  assign o_tx_TLAST       = tx_vld;
  assign o_tx_TDATA       = req_data;
  assign o_tx_TKEEP       = req_keep;
  assign o_remote_ip_tx   = req_ip;
  assign o_remote_port_tx = req_rport;
  assign o_local_port_tx  = req_lport;
  assign o_rx_TREADY      = rx_rdy;
  assign o_busy           = (state != IDLE);
  assign o_done           = done_q;
  assign o_err_timeout    = err_q;
  assign o_rsp_data       = rsp_data;
  assign o_rsp_keep       = rsp_keep;
  assign o_drop_count     = drop_cnt;

endmodule
